mmio_ctrl: RTL and testbench

- Memory-mapped I/O controller directly downstream of the single-cycle CPU's load/store path.
- Decodes data-bus addresses in the 0xF000_00xx page and holds the output registers for HEX, LEDR and LEDG.
- Synchronizes and debounces KEY and SW, and returns their values on loads.
- The CPU muxes rdData over DMem output whenever ioHit=1.

---
 rtl/mmio_ctrl_pkg.sv | 27 ++
 rtl/mmio_ctrl_sevenseg_dec.sv | 11 +
 rtl/mmio_ctrl.sv | 139 +++++++++++++
 tb/tb_mmio_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mmio_ctrl_pkg.sv
// Shared constants for the MMIO controller: bus width, register map and seven-segment digit table.
package mmio_ctrl_pkg;

    localparam int          MMIO_DBITS     = 32;
    localparam logic [31:0] MMIO_ADDR_HEX  = 32'hF000_0000;
    localparam logic [31:0] MMIO_ADDR_LEDR = 32'hF000_0004;
    localparam logic [31:0] MMIO_ADDR_LEDG = 32'hF000_0008;
    localparam logic [31:0] MMIO_ADDR_KEY  = 32'hF000_0010;
    localparam logic [31:0] MMIO_ADDR_SW   = 32'hF000_0014;

    localparam int NUM_KEY = 4;
    localparam int NUM_SW  = 10;
    localparam int NUM_IN  = NUM_KEY + NUM_SW;

    // Active-low segments, bit order {g,f,e,d,c,b,a}; entry n is hex digit n.
    localparam logic [15:0][6:0] SEG_LUT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
    };

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        return SEG_LUT[d];
    endfunction

endpackage

// File: rtl/mmio_ctrl_sevenseg_dec.sv
// Hex digit to active-low seven-segment pattern.
module sevenseg_dec
    import mmio_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = seg_of(digit);

endmodule

// File: rtl/mmio_ctrl.sv
// Memory-mapped HEX/LEDR/LEDG output registers and debounced KEY/SW inputs.
// Define MMIO_KEY_EDGE_EN to add sticky, write-1-to-clear KEY press flags in KEY read bits [7:4].
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int               DBITS      = MMIO_DBITS,
    parameter logic [DBITS-1:0] ADDR_HEX   = MMIO_ADDR_HEX[DBITS-1:0],
    parameter logic [DBITS-1:0] ADDR_LEDR  = MMIO_ADDR_LEDR[DBITS-1:0],
    parameter logic [DBITS-1:0] ADDR_LEDG  = MMIO_ADDR_LEDG[DBITS-1:0],
    parameter logic [DBITS-1:0] ADDR_KEY   = MMIO_ADDR_KEY[DBITS-1:0],
    parameter logic [DBITS-1:0] ADDR_SW    = MMIO_ADDR_SW[DBITS-1:0],
    parameter logic [15:0]      DEB_CYCLES = 16'd50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wrData,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdData,
    output logic             ioHit,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [9:0]       LEDR,
    output logic [7:0]       LEDG
);

    logic [DBITS-3:0] wordAddr;
    logic hitHex, hitLedr, hitLedg, hitKey, hitSw;

    assign wordAddr = addr[DBITS-1:2];
    assign hitHex   = (wordAddr == ADDR_HEX[DBITS-1:2]);
    assign hitLedr  = (wordAddr == ADDR_LEDR[DBITS-1:2]);
    assign hitLedg  = (wordAddr == ADDR_LEDG[DBITS-1:2]);
    assign hitKey   = (wordAddr == ADDR_KEY[DBITS-1:2]);
    assign hitSw    = (wordAddr == ADDR_SW[DBITS-1:2]);
    assign ioHit    = hitHex | hitLedr | hitLedg | hitKey | hitSw;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wrData[DBITS-1:16]};

    // Output registers
    logic [15:0] hexReg;
    logic [9:0]  ledrReg;
    logic [7:0]  ledgReg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hexReg  <= '0;
            ledrReg <= '0;
            ledgReg <= '0;
        end else if (we) begin
            if (hitHex)  hexReg  <= wrData[15:0];
            if (hitLedr) ledrReg <= wrData[9:0];
            if (hitLedg) ledgReg <= wrData[7:0];
        end
    end

    assign LEDR = ledrReg;
    assign LEDG = ledgReg;

    logic [3:0][6:0] hexSeg;
    for (genvar i = 0; i < 4; i++) begin : g_seg
        sevenseg_dec u_dec (
            .digit (hexReg[4*i +: 4]),
            .seg   (hexSeg[i])
        );
    end
    assign HEX0 = hexSeg[0];
    assign HEX1 = hexSeg[1];
    assign HEX2 = hexSeg[2];
    assign HEX3 = hexSeg[3];

    // Input path: bits [3:0] are KEY (inverted so 1 = pressed), [13:4] are SW.
    logic [NUM_IN-1:0] sync1, sync2, samp, deb, debNxt, stable;
    logic [15:0]       tickCnt;
    logic              tick;

    assign tick   = (tickCnt == DEB_CYCLES - 16'd1);
    assign stable = ~(sync2 ^ samp);

    always_comb begin
        debNxt = deb;
        if (tick) debNxt = (deb & ~stable) | (sync2 & stable);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            samp    <= '0;
            deb     <= '0;
            tickCnt <= '0;
        end else begin
            sync1   <= {SW, ~KEY};
            sync2   <= sync1;
            tickCnt <= tick ? 16'd0 : tickCnt + 16'd1;
            if (tick) samp <= sync2;
            deb     <= debNxt;
        end
    end

    logic [3:0] keyDeb;
    logic [9:0] swDeb;
    assign keyDeb = deb[3:0];
    assign swDeb  = deb[13:4];

`ifdef MMIO_KEY_EDGE_EN
    logic [3:0] keyEdge, keySet, keyClr;
    assign keySet = debNxt[3:0] & ~deb[3:0];
    assign keyClr = (we && hitKey) ? wrData[7:4] : 4'd0;

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) keyEdge <= '0;
        else        keyEdge <= (keyEdge & ~keyClr) | keySet;
    end
`endif

    always_comb begin
        rdData = '0;
        if (re) begin
            if (hitHex)       rdData = {{(DBITS-16){1'b0}}, hexReg};
            else if (hitLedr) rdData = {{(DBITS-10){1'b0}}, ledrReg};
            else if (hitLedg) rdData = {{(DBITS-8){1'b0}}, ledgReg};
`ifdef MMIO_KEY_EDGE_EN
            else if (hitKey)  rdData = {{(DBITS-8){1'b0}}, keyEdge, keyDeb};
`else
            else if (hitKey)  rdData = {{(DBITS-4){1'b0}}, keyDeb};
`endif
            else if (hitSw)   rdData = {{(DBITS-10){1'b0}}, swDeb};
        end
    end

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed vector bench for mmio_ctrl with a short debounce period.
module tb_mmio_ctrl;

    localparam logic [31:0] A_HEX  = 32'hF000_0000;
    localparam logic [31:0] A_LEDR = 32'hF000_0004;
    localparam logic [31:0] A_LEDG = 32'hF000_0008;
    localparam logic [31:0] A_KEY  = 32'hF000_0010;
    localparam logic [31:0] A_SW   = 32'hF000_0014;

    localparam logic [6:0] S_0 = 7'b1000000;
    localparam logic [6:0] S_B = 7'b0000011;
    localparam logic [6:0] S_E = 7'b0000110;
    localparam logic [6:0] S_F = 7'b0001110;
    localparam logic [27:0] H_RST  = {S_0, S_0, S_0, S_0};
    localparam logic [27:0] H_BEEF = {S_B, S_E, S_E, S_F};

`ifdef MMIO_KEY_EDGE_EN
    localparam logic [31:0] KEY_PRESSED  = 32'h44;
    localparam logic [31:0] KEY_RELEASED = 32'h40;
`else
    localparam logic [31:0] KEY_PRESSED  = 32'h04;
    localparam logic [31:0] KEY_RELEASED = 32'h00;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, wrData = '0, rdData;
    logic        we = 1'b0, re = 1'b0, ioHit;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3;
    logic [9:0]  LEDR;
    logic [7:0]  LEDG;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_ctrl #(.DEB_CYCLES(16'd4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wrData(wrData), .we(we), .re(re),
        .rdData(rdData), .ioHit(ioHit), .KEY(KEY), .SW(SW),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .LEDR(LEDR), .LEDG(LEDG)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Read addr every cycle until the masked value matches or the cycle budget runs out.
    task automatic poll(input logic [31:0] a, input logic [31:0] mask, input logic [31:0] exp,
                        input int maxc, output logic [31:0] val, output int n);
        addr = a; re = 1'b1; we = 1'b0;
        n = 0;
        #1;
        val = rdData;
        while (((val & mask) !== exp) && n < maxc) begin
            step();
            n++;
            val = rdData;
        end
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_hit;
        logic [9:0]  exp_ledr;
        logic [7:0]  exp_ledg;
        logic [27:0] exp_hex;
    } vec_t;

    vec_t vec[18];

    initial begin
        logic [31:0] v;
        int n, bad;

        vec[0]  = '{1'b0, 1'b1, A_HEX,         32'h0,        32'h0,    1'b1, 10'h0,   8'h00, H_RST};
        vec[1]  = '{1'b0, 1'b1, A_KEY,         32'h0,        32'h0,    1'b1, 10'h0,   8'h00, H_RST};
        vec[2]  = '{1'b0, 1'b1, A_SW,          32'h0,        32'h0,    1'b1, 10'h0,   8'h00, H_RST};
        vec[3]  = '{1'b1, 1'b1, A_HEX,         32'h0000BEEF, 32'h0,    1'b1, 10'h0,   8'h00, H_BEEF};
        vec[4]  = '{1'b0, 1'b1, A_HEX,         32'h0,        32'hBEEF, 1'b1, 10'h0,   8'h00, H_BEEF};
        vec[5]  = '{1'b1, 1'b1, A_LEDR,        32'hFFFFFFFF, 32'h0,    1'b1, 10'h3FF, 8'h00, H_BEEF};
        vec[6]  = '{1'b1, 1'b1, A_LEDG,        32'hFFFFFFFF, 32'h0,    1'b1, 10'h3FF, 8'hFF, H_BEEF};
        vec[7]  = '{1'b0, 1'b1, A_LEDR,        32'h0,        32'h3FF,  1'b1, 10'h3FF, 8'hFF, H_BEEF};
        vec[8]  = '{1'b0, 1'b1, A_LEDG,        32'h0,        32'hFF,   1'b1, 10'h3FF, 8'hFF, H_BEEF};
        vec[9]  = '{1'b1, 1'b1, 32'hF000000C,  32'h12345678, 32'h0,    1'b0, 10'h3FF, 8'hFF, H_BEEF};
        vec[10] = '{1'b0, 1'b1, 32'hF000000C,  32'h0,        32'h0,    1'b0, 10'h3FF, 8'hFF, H_BEEF};
        vec[11] = '{1'b0, 1'b0, A_LEDR,        32'h0,        32'h0,    1'b1, 10'h3FF, 8'hFF, H_BEEF};
        vec[12] = '{1'b0, 1'b1, 32'hF0000006,  32'h0,        32'h3FF,  1'b1, 10'h3FF, 8'hFF, H_BEEF};
        vec[13] = '{1'b1, 1'b1, 32'hF0000006,  32'h00000155, 32'h3FF,  1'b1, 10'h155, 8'hFF, H_BEEF};
        vec[14] = '{1'b0, 1'b1, A_LEDR,        32'h0,        32'h155,  1'b1, 10'h155, 8'hFF, H_BEEF};
        vec[15] = '{1'b1, 1'b1, A_SW,          32'h0000FFFF, 32'h0,    1'b1, 10'h155, 8'hFF, H_BEEF};
        vec[16] = '{1'b0, 1'b1, A_SW,          32'h0,        32'h0,    1'b1, 10'h155, 8'hFF, H_BEEF};
        vec[17] = '{1'b0, 1'b1, 32'hE0000004,  32'h0,        32'h0,    1'b0, 10'h155, 8'hFF, H_BEEF};

        #3;
        chk("rst_hex", {HEX3, HEX2, HEX1, HEX0}, {4'h0, H_RST});
        chk("rst_ledr", {22'h0, LEDR}, 32'h0);
        chk("rst_ledg", {24'h0, LEDG}, 32'h0);
        #10 reset = 1'b1;
        step();

        for (int i = 0; i < 18; i++) begin
            we = vec[i].we; re = vec[i].re; addr = vec[i].addr; wrData = vec[i].wd;
            #1;
            chk($sformatf("v%0d_rd", i), rdData, vec[i].exp_rd);
            chk($sformatf("v%0d_hit", i), {31'h0, ioHit}, {31'h0, vec[i].exp_hit});
            step();
            we = 1'b0;
            chk($sformatf("v%0d_ledr", i), {22'h0, LEDR}, {22'h0, vec[i].exp_ledr});
            chk($sformatf("v%0d_ledg", i), {24'h0, LEDG}, {24'h0, vec[i].exp_ledg});
            chk($sformatf("v%0d_hex", i), {HEX3, HEX2, HEX1, HEX0}, {4'h0, vec[i].exp_hex});
        end

        // Switch debounce: worst-case latency is 2 + 2*4 cycles.
        SW = 10'h2A5;
        poll(A_SW, 32'hFFFF_FFFF, 32'h2A5, 12, v, n);
        chk("sw_settle_val", v, 32'h2A5);
        chk("sw_settle_lat", {31'h0, n <= 10}, 32'h1);

        // One-cycle glitch must never reach the debounced value.
        SW = 10'h000;
        step();
        SW = 10'h2A5;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (rdData !== 32'h2A5) bad++;
            step();
        end
        chk("sw_glitch_hold", bad, 0);

        SW = 10'h15A;
        poll(A_SW, 32'hFFFF_FFFF, 32'h15A, 12, v, n);
        chk("sw_change_val", v, 32'h15A);

        // KEY[2] pressed (active-low on the board).
        KEY = 4'b1011;
        poll(A_KEY, 32'h0000_000F, 32'h4, 12, v, n);
        chk("key_press", v, KEY_PRESSED);
        KEY = 4'b1111;
        poll(A_KEY, 32'h0000_000F, 32'h0, 12, v, n);
        chk("key_release", v, KEY_RELEASED);
        addr = A_KEY; wrData = 32'h40; we = 1'b1; re = 1'b1;
        #1;
        chk("key_w1c_old", rdData, KEY_RELEASED);
        step();
        we = 1'b0;
        #1;
        chk("key_w1c_new", rdData, 32'h0);

        // Reset in the middle of a debounce window.
        addr = A_LEDR; wrData = 32'h2AA; we = 1'b1; re = 1'b0;
        step();
        we = 1'b0;
        chk("ledr_pre_rst", {22'h0, LEDR}, 32'h2AA);
        SW = 10'h3FF;
        repeat (5) step();
        reset = 1'b0;
        #2;
        chk("mid_rst_ledr", {22'h0, LEDR}, 32'h0);
        chk("mid_rst_hex0", {25'h0, HEX0}, {25'h0, S_0});
        @(negedge clk);
        reset = 1'b1;
        addr = A_SW; re = 1'b1;
        #1;
        chk("mid_rst_sw", rdData, 32'h0);
        poll(A_SW, 32'hFFFF_FFFF, 32'h3FF, 14, v, n);
        chk("post_rst_sw", v, 32'h3FF);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
